// File: rtl/vdp_vram_arbiter.sv
// ---------------------------------------------------------------------------
// vdp_vram_arbiter
//
// Shares the single VRAM port between three clients:
//   - background tile fetcher : owns every slot of the 8-cycle pattern except
//                               the free slots while the display is active
//   - CPU data port           : highest priority in any free slot
//   - sprite fetcher          : takes free slots the CPU does not want
// Outside active display every cycle is free. CPU and sprite then share the
// port by round-robin.
//
// The owner of cycle N is decided combinationally, and vram_a/we/wd are muxed
// straight from that owner's inputs. This keeps the background fetch timing
// unchanged. The RAM registers the address, so read data arrives in N+1. The
// owner is also registered so the read data can be routed back in N+1.
//
// Ports
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   active, slot, bg_a    background fetcher state and address
//   spr_req/spr_a         sprite request (level) and address
//   spr_gnt               sprite access issued this cycle (combinational)
//   spr_valid             vram_d carries sprite read data
//   cpu_req/we/a/wd       CPU request (level), direction, address, write data
//   cpu_ack               one-cycle completion pulse, cycle after the access
//   cpu_rd                CPU read data, valid with cpu_ack on a read
//   vram_a/we/wd          VRAM port (address registered inside the RAM)
//   vram_d                VRAM read data, one cycle after vram_a
//
// Optional build macro VDP_VRAM_ARB_STATS_EN adds:
//   stats_clr             synchronous clear of the wait statistics
//   cpu_wait_max          longest CPU wait seen so far, saturating at 255
// ---------------------------------------------------------------------------
module vdp_vram_arbiter #(
    parameter int          AW         = 14,
    parameter int          DW         = 8,
    parameter logic [7:0]  FREE_SLOTS = 8'b1000_0100
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          active,
    input  logic [2:0]    slot,
    input  logic [AW-1:0] bg_a,
    input  logic          spr_req,
    input  logic [AW-1:0] spr_a,
    output logic          spr_gnt,
    output logic          spr_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_wd,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rd,
`ifdef VDP_VRAM_ARB_STATS_EN
    input  logic          stats_clr,
    output logic [7:0]    cpu_wait_max,
`endif
    output logic [AW-1:0] vram_a,
    output logic          vram_we,
    output logic [DW-1:0] vram_wd,
    input  logic [DW-1:0] vram_d
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_BG   = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_SPR  = 2'd3
    } owner_t;

    // Which requester wins the next contended inactive-display cycle
    typedef enum logic {
        RR_CPU = 1'b0,
        RR_SPR = 1'b1
    } rr_t;

    owner_t owner_s;
    owner_t owner_r;
    rr_t    rr_r;
    logic   slot_free_s;
    logic   cpu_ok_s;
    logic   cpu_ack_r;
    logic   spr_valid_r;

    // Pick the owner of the current cycle
    always_comb begin
        owner_s     = OWN_IDLE;
        slot_free_s = !active || FREE_SLOTS[slot];
        // A request still high in its own ack cycle is the old, completed one
        cpu_ok_s    = cpu_req && !cpu_ack_r;
        if (!slot_free_s) begin
            owner_s = OWN_BG;
        end else begin
            case ({cpu_ok_s, spr_req})
                2'b10:   owner_s = OWN_CPU;
                2'b01:   owner_s = OWN_SPR;
                2'b11: begin
                    // During active display the CPU always wins free slots so
                    // its wait stays bounded; sprites fetch in blanking.
                    if (active) begin
                        owner_s = OWN_CPU;
                    end else if (rr_r == RR_SPR) begin
                        owner_s = OWN_SPR;
                    end else begin
                        owner_s = OWN_CPU;
                    end
                end
                default: owner_s = OWN_IDLE;
            endcase
        end
    end

    // Drive the VRAM port from the current owner's inputs
    always_comb begin
        vram_a  = bg_a;
        vram_we = 1'b0;
        vram_wd = {DW{1'b0}};
        spr_gnt = 1'b0;
        case (owner_s)
            OWN_CPU: begin
                vram_a  = cpu_a;
                vram_we = cpu_we;
                vram_wd = cpu_wd;
            end
            OWN_SPR: begin
                vram_a  = spr_a;
                spr_gnt = 1'b1;
            end
            default: begin
                vram_a  = bg_a;
                vram_we = 1'b0;
            end
        endcase
    end

    // Remember who issued this cycle's access and rotate round-robin priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r     <= OWN_IDLE;
            rr_r        <= RR_CPU;
            cpu_ack_r   <= 1'b0;
            spr_valid_r <= 1'b0;
        end else begin
            owner_r     <= owner_s;
            cpu_ack_r   <= (owner_s == OWN_CPU);
            spr_valid_r <= (owner_s == OWN_SPR);
            case (owner_s)
                OWN_CPU: rr_r <= RR_SPR;
                OWN_SPR: rr_r <= RR_CPU;
                default: rr_r <= rr_r;
            endcase
        end
    end

    assign cpu_ack   = cpu_ack_r;
    assign spr_valid = spr_valid_r;

    // Read data is only passed through in the CPU's return cycle
    always_comb begin
        if (owner_r == OWN_CPU) begin
            cpu_rd = vram_d;
        end else begin
            cpu_rd = {DW{1'b0}};
        end
    end

`ifdef VDP_VRAM_ARB_STATS_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    logic [7:0] wait_cnt_r;
    logic [7:0] wait_max_r;
    logic [7:0] wait_inc_s;
    logic       cpu_blocked_s;

    // A cycle counts as waiting when a live CPU request is not granted
    always_comb begin
        cpu_blocked_s = cpu_ok_s && (owner_s != OWN_CPU);
        wait_inc_s    = sat_inc(wait_cnt_r);
    end

    // Track the current wait length and the longest one seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 8'd0;
            wait_max_r <= 8'd0;
        end else if (stats_clr) begin
            wait_cnt_r <= 8'd0;
            wait_max_r <= 8'd0;
        end else if (cpu_blocked_s) begin
            wait_cnt_r <= wait_inc_s;
            if (wait_inc_s > wait_max_r) begin
                wait_max_r <= wait_inc_s;
            end else begin
                wait_max_r <= wait_max_r;
            end
        end else begin
            wait_cnt_r <= 8'd0;
            wait_max_r <= wait_max_r;
        end
    end

    assign cpu_wait_max = wait_max_r;
`endif

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
module tb_vdp_vram_arbiter;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int O_IDLE = 0;
    localparam int O_BG   = 1;
    localparam int O_CPU  = 2;
    localparam int O_SPR  = 3;

    logic          clk;
    logic          rst_n;
    logic          active;
    logic [2:0]    slot;
    logic [AW-1:0] bg_a;
    logic          spr_req;
    logic [AW-1:0] spr_a;
    logic          spr_gnt;
    logic          spr_valid;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_a;
    logic [DW-1:0] cpu_wd;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rd;
    logic [AW-1:0] vram_a;
    logic          vram_we;
    logic [DW-1:0] vram_wd;
    logic [DW-1:0] vram_d;
`ifdef VDP_VRAM_ARB_STATS_EN
    logic          stats_clr;
    logic [7:0]    cpu_wait_max;
`endif

    vdp_vram_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (active),
        .slot      (slot),
        .bg_a      (bg_a),
        .spr_req   (spr_req),
        .spr_a     (spr_a),
        .spr_gnt   (spr_gnt),
        .spr_valid (spr_valid),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_a     (cpu_a),
        .cpu_wd    (cpu_wd),
        .cpu_ack   (cpu_ack),
        .cpu_rd    (cpu_rd),
`ifdef VDP_VRAM_ARB_STATS_EN
        .stats_clr    (stats_clr),
        .cpu_wait_max (cpu_wait_max),
`endif
        .vram_a    (vram_a),
        .vram_we   (vram_we),
        .vram_wd   (vram_wd),
        .vram_d    (vram_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM block RAM: registered address, read-before-write
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (vram_we) mem[vram_a] <= vram_wd;
        vram_d <= mem[vram_a];
    end

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic          m_ack;
    logic          m_ack_we;
    logic [DW-1:0] m_rd;
    logic          m_valid;
    logic          m_prefer_spr;
    int            last_own;
    logic [2:0]    last_slot;
    logic          ack_seen;
    logic          auto_slot;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] rnd_a();
        logic [31:0] r;
        r = $urandom;
        return r[AW-1:0];
    endfunction

    function automatic logic [DW-1:0] rnd_d();
        logic [31:0] r;
        r = $urandom;
        return r[DW-1:0];
    endfunction

    function automatic logic rnd_chance(input int one_in);
        return ($urandom_range(0, one_in - 1) == 0);
    endfunction

    // Owner of this cycle from the arbitration rules
    function automatic int ref_owner();
        bit free_slot;
        bit cpu_wants;
        free_slot = !active || (slot == 3'd2) || (slot == 3'd7);
        cpu_wants = cpu_req && !m_ack;
        if (!free_slot) return O_BG;
        if (!cpu_wants && !spr_req) return O_IDLE;
        if (cpu_wants && !spr_req) return O_CPU;
        if (!cpu_wants && spr_req) return O_SPR;
        if (active) return O_CPU;
        return m_prefer_spr ? O_SPR : O_CPU;
    endfunction

    task automatic model_reset();
        m_ack        = 1'b0;
        m_ack_we     = 1'b0;
        m_rd         = '0;
        m_valid      = 1'b0;
        m_prefer_spr = 1'b0;
        last_own     = O_IDLE;
        ack_seen     = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, advance model at rising edge
    task automatic step();
        int            eo;
        logic [AW-1:0] ea;
        @(negedge clk);
        eo = ref_owner();
        ea = (eo == O_CPU) ? cpu_a : (eo == O_SPR) ? spr_a : bg_a;
        chk("vram_a", {18'd0, vram_a}, {18'd0, ea});
        chk("vram_we", {31'd0, vram_we}, {31'd0, (eo == O_CPU) && cpu_we});
        chk("spr_gnt", {31'd0, spr_gnt}, {31'd0, eo == O_SPR});
        chk("cpu_ack", {31'd0, cpu_ack}, {31'd0, m_ack});
        chk("spr_valid", {31'd0, spr_valid}, {31'd0, m_valid});
        if (m_ack && !m_ack_we) chk("cpu_rd", {24'd0, cpu_rd}, {24'd0, m_rd});
        if (eo == O_CPU && cpu_we) chk("vram_wd", {24'd0, vram_wd}, {24'd0, cpu_wd});
        last_own  = eo;
        last_slot = slot;
        ack_seen  = m_ack;
        @(posedge clk);
        m_ack    = (eo == O_CPU);
        m_ack_we = cpu_we;
        m_rd     = ref_mem[cpu_a];
        m_valid  = (eo == O_SPR);
        if (eo == O_CPU) begin
            if (cpu_we) ref_mem[cpu_a] = cpu_wd;
            m_prefer_spr = 1'b1;
        end else if (eo == O_SPR) begin
            m_prefer_spr = 1'b0;
        end
        #1;
        if (auto_slot) slot = slot + 3'd1;
        bg_a = rnd_a();
    endtask

    initial begin
        int  waitc;
        bit  got;
        logic [DW-1:0] v;

        rst_n = 1'b0; active = 1'b0; slot = 3'd0; bg_a = '0;
        spr_req = 1'b0; spr_a = '0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_a = '0; cpu_wd = '0; auto_slot = 1'b1;
`ifdef VDP_VRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        for (int i = 0; i < (1 << AW); i++) begin
            v = rnd_d();
            mem[i] = v;
            ref_mem[i] = v;
        end
        model_reset();
        #2;
        chk("reset_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("reset_spr_valid", {31'd0, spr_valid}, 32'd0);
        chk("reset_cpu_rd", {24'd0, cpu_rd}, 32'd0);
        #10;
        rst_n = 1'b1;

        // 1: background owns the port, nothing else happens
        active = 1'b1;
        slot   = 3'd0;
        for (int i = 0; i < 16; i++) step();

        // 2: CPU read issued at slot 3 waits for free slot 7
        slot = 3'd3; cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 14'h1234;
        waitc = 0; got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            if (last_own == O_CPU) got = 1'b1;
            else waitc++;
        end
        chk("t2_granted", {31'd0, got}, 32'd1);
        chk("t2_grant_slot", {29'd0, last_slot}, 32'd7);
        chk("t2_wait", waitc, 32'd4);
        step();
        chk("t2_ack_slot", {29'd0, last_slot}, 32'd0);
        chk("t2_ack_seen", {31'd0, ack_seen}, 32'd1);
`ifdef VDP_VRAM_ARB_STATS_EN
        chk("t2_wait_max", {24'd0, cpu_wait_max}, 32'd4);
`endif
        cpu_req = 1'b0;

        // 3: CPU write and sprite request together at slot 1
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 14'h0200; cpu_wd = 8'hA5;
        spr_req = 1'b1; spr_a = rnd_a();
        step();
        chk("t3_slot1_owner", last_own, O_BG);
        step();
        chk("t3_cpu_owner", last_own, O_CPU);
        chk("t3_cpu_slot", {29'd0, last_slot}, 32'd2);
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            if (last_own == O_SPR) got = 1'b1;
        end
        chk("t3_spr_granted", {31'd0, got}, 32'd1);
        chk("t3_spr_slot", {29'd0, last_slot}, 32'd7);
        spr_req = 1'b0;
        step();
        chk("t3_valid_slot", {29'd0, last_slot}, 32'd0);
        chk("t3_ram", {24'd0, mem[14'h0200]}, 32'h0000_00A5);

        // 4: blanking, both requesting continuously -> strict alternation
        active = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = rnd_a();
        spr_req = 1'b1; spr_a = rnd_a();
        for (int i = 0; i < 12; i++) begin
            step();
            chk("t4_owner", last_own, (i % 2 == 0) ? O_CPU : O_SPR);
        end

        // 5: reset asserted in the cycle the read data comes back
        spr_req = 1'b0;
        step();
        chk("t5_grant", last_own, O_CPU);
        chk("t5_ack_before", {31'd0, cpu_ack}, 32'd1);
        spr_req = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t5_ack_drop", {31'd0, cpu_ack}, 32'd0);
        chk("t5_valid_drop", {31'd0, spr_valid}, 32'd0);
        chk("t5_rd_drop", {24'd0, cpu_rd}, 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        step();
        chk("t5_first_after_reset", last_own, O_CPU);
        step();
        cpu_req = 1'b0; spr_req = 1'b0;
        step();

        // Random traffic with protocol-respecting requesters
        for (int i = 0; i < 400; i++) begin
            if (rnd_chance(32)) active = ~active;
            if (last_own == O_CPU) begin
                // request still held through its ack cycle
            end else if (cpu_req && !ack_seen) begin
                // still waiting for a grant
            end else begin
                cpu_req = rnd_chance(3);
                cpu_we  = rnd_chance(2);
                cpu_a   = rnd_a();
                cpu_wd  = rnd_d();
            end
            if (!(spr_req && last_own != O_SPR)) begin
                spr_req = rnd_chance(3);
                spr_a   = rnd_a();
            end
            step();
        end
        cpu_req = 1'b0; spr_req = 1'b0;
        step();
        step();

`ifdef VDP_VRAM_ARB_STATS_EN
        // 6: CPU held off for 300 busy cycles -> saturated maximum, then clear
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        active = 1'b1; auto_slot = 1'b0; slot = 3'd0;
        cpu_req = 1'b1; cpu_we = 1'b0;
        for (int i = 0; i < 300; i++) step();
        chk("t6_wait_max_sat", {24'd0, cpu_wait_max}, 32'd255);
        cpu_req = 1'b0;
        stats_clr = 1'b1;
        step();
        chk("t6_wait_max_clr", {24'd0, cpu_wait_max}, 32'd0);
        stats_clr = 1'b0;
        auto_slot = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
